// File: rtl/timer_counter.sv
// Memory-mapped timer/counter: one-shot (level irq) or auto-reload (pulse irq),
// programmed through word registers CTRL, PRESET and COUNT.
//   state | meaning
//   IDLE  | waiting for EN, COUNT holds last value
//   LOAD  | COUNT <= PRESET
//   CNT   | decrementing toward terminal count
//   INT   | terminal count reached, pending raised
module timer_counter #(
    parameter logic [31:0] RST_PRESET = 32'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  addr,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } state_t;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_PRESET = 2'd1;
    localparam logic [1:0] ADDR_COUNT  = 2'd2;

    state_t      state_q, state_d;
    logic [3:0]  ctrl_q, ctrl_d;
    logic [31:0] preset_q, preset_d;
    logic [31:0] count_q, count_d;
    logic        pending_q, pending_d;

    logic        en;
    logic        im;
    logic        auto_reload;
    logic        wr_ctrl;
    logic        wr_preset;

    assign en          = ctrl_q[0];
    assign im          = ctrl_q[3];
    // Only MODE=1 reloads; MODE 2 and 3 fall back to one-shot behaviour.
    assign auto_reload = (ctrl_q[2:1] == 2'b01);
    assign wr_ctrl     = we && (addr == ADDR_CTRL);
    assign wr_preset   = we && (addr == ADDR_PRESET);

    always_comb begin
        state_d   = state_q;
        ctrl_d    = ctrl_q;
        preset_d  = preset_q;
        count_d   = count_q;
        pending_d = pending_q;

        case (state_q)
            ST_IDLE: begin
                if (en) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                count_d = preset_q;
                state_d = en ? ST_CNT : ST_IDLE;
            end
            ST_CNT: begin
                if (!en) begin
                    state_d = ST_IDLE;
                end else if (count_q > 32'd1) begin
                    count_d = count_q - 32'd1;
                end else begin
                    count_d   = 32'd0;
                    pending_d = 1'b1;
                    state_d   = ST_INT;
                end
            end
            ST_INT: begin
                if (auto_reload) begin
                    pending_d = 1'b0;
                    state_d   = en ? ST_LOAD : ST_IDLE;
                end else begin
                    ctrl_d[0] = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // CPU writes come last so they override the FSM's own EN clear.
        if (wr_ctrl) begin
            ctrl_d    = wdata[3:0];
            pending_d = 1'b0;
        end
        if (wr_preset) begin
            preset_d  = wdata;
            pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            ctrl_q    <= 4'd0;
            preset_q  <= RST_PRESET;
            count_q   <= 32'd0;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ctrl_q    <= ctrl_d;
            preset_q  <= preset_d;
            count_q   <= count_d;
            pending_q <= pending_d;
        end
    end

    always_comb begin
        rdata = 32'd0;
        case (addr)
            ADDR_CTRL:   rdata = {28'd0, ctrl_q};
            ADDR_PRESET: rdata = preset_q;
            ADDR_COUNT:  rdata = count_q;
            default:     rdata = 32'd0;
        endcase
    end

    assign irq = pending_q & im;

endmodule

// File: tb/tb_timer_counter.sv
// Directed bench for timer_counter: reset, one-shot, auto-reload, masking,
// disable mid-count and the edge cases around PRESET and reset.
module tb_timer_counter;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    int n_tests = 0;
    int n_fail  = 0;

    timer_counter #(.RST_PRESET(32'd0)) dut (
        .clk   (clk),
        .reset (reset),
        .addr  (addr),
        .we    (we),
        .wdata (wdata),
        .rdata (rdata),
        .irq   (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%08h), expected %0d (0x%08h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        tick();
        we    = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        addr = a;
        #1;
        d = rdata;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Poll COUNT until it reads the target value; an expired budget is a failure.
    task automatic wait_count(input logic [31:0] target, input string tag);
        logic [31:0] v;
        bit found = 0;
        for (int i = 0; i < 60; i++) begin
            rd(2'd2, v);
            if (v == target) begin
                found = 1;
                break;
            end
            tick();
        end
        check(tag, {31'd0, found}, 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v;
        int hi;
        bit seen3, seen0;

        reset = 1'b1;
        we    = 1'b0;
        addr  = 2'd0;
        wdata = 32'd0;

        // Reset values
        do_reset();
        rd(2'd0, v); check("rst_ctrl", v, 32'd0);
        rd(2'd1, v); check("rst_preset", v, 32'd0);
        rd(2'd2, v); check("rst_count", v, 32'd0);
        rd(2'd3, v); check("rst_addr3", v, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        wr(2'd2, 32'h55);
        wr(2'd3, 32'h66);
        rd(2'd2, v); check("count_ro", v, 32'd0);
        rd(2'd3, v); check("addr3_ro", v, 32'd0);
        wr(2'd0, 32'hFFFF_FFF0);
        rd(2'd0, v); check("ctrl_hi_zero", v, 32'd0);

        // Mode 0 one-shot, PRESET=5
        do_reset();
        wr(2'd1, 32'd5);
        wr(2'd0, 32'h9);
        tick();
        tick();
        rd(2'd2, v); check("m0_count_e2", v, 32'd5);
        for (int i = 4; i >= 1; i--) begin
            tick();
            rd(2'd2, v); check($sformatf("m0_count_%0d", i), v, i);
        end
        check("m0_irq_e6", {31'd0, irq}, 32'd0);
        tick();
        rd(2'd2, v); check("m0_count_e7", v, 32'd0);
        check("m0_irq_e7", {31'd0, irq}, 32'd1);
        hi = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (irq) hi++;
        end
        check("m0_irq_level", hi, 32'd12);
        rd(2'd0, v); check("m0_en_cleared", v, 32'h8);
        wr(2'd0, 32'h8);
        check("m0_irq_clear", {31'd0, irq}, 32'd0);

        // Mode 1 auto-reload, PRESET=3: pulse after E5, E10, E15, E20
        do_reset();
        wr(2'd1, 32'd3);
        wr(2'd0, 32'hB);
        for (int k = 1; k <= 20; k++) begin
            tick();
            check($sformatf("m1_irq_e%0d", k), {31'd0, irq}, ((k % 5) == 0) ? 32'd1 : 32'd0);
        end
        wr(2'd0, 32'h3);
        hi = 0;
        seen3 = 0;
        seen0 = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (irq) hi++;
            rd(2'd2, v);
            if (v == 32'd3) seen3 = 1;
            if (v == 32'd0) seen0 = 1;
        end
        check("m1_masked_irq", hi, 32'd0);
        check("m1_reload_seen", {31'd0, seen3}, 32'd1);
        check("m1_zero_seen", {31'd0, seen0}, 32'd1);

        // Masked interrupt: PRESET=2, CTRL=0001
        do_reset();
        wr(2'd1, 32'd2);
        wr(2'd0, 32'h1);
        hi = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (irq) hi++;
        end
        check("mask_irq_low", hi, 32'd0);
        check("mask_pending", {31'd0, dut.pending_q}, 32'd1);
        wr(2'd0, 32'h8);
        check("mask_pending_clr", {31'd0, dut.pending_q}, 32'd0);
        tick();
        check("mask_irq_after_im", {31'd0, irq}, 32'd0);

        // Disable mid-count at COUNT=6 -> freezes at 5
        do_reset();
        wr(2'd1, 32'd10);
        wr(2'd0, 32'h1);
        wait_count(32'd6, "dis_reach6");
        wr(2'd0, 32'h0);
        tick();
        rd(2'd2, v); check("dis_frozen", v, 32'd5);
        tick();
        tick();
        rd(2'd2, v); check("dis_frozen_hold", v, 32'd5);
        check("dis_irq", {31'd0, irq}, 32'd0);
        wr(2'd0, 32'h1);
        tick();
        tick();
        rd(2'd2, v); check("dis_reload", v, 32'd10);

        // PRESET=0 behaves like PRESET=1
        do_reset();
        wr(2'd1, 32'd0);
        wr(2'd0, 32'h9);
        tick();
        tick();
        check("p0_irq_e2", {31'd0, irq}, 32'd0);
        tick();
        check("p0_irq_e3", {31'd0, irq}, 32'd1);

        // PRESET write during CNT leaves the running count alone
        do_reset();
        wr(2'd1, 32'd4);
        wr(2'd0, 32'h9);
        tick();
        tick();
        tick();
        rd(2'd2, v); check("pw_count_e3", v, 32'd3);
        wr(2'd1, 32'd100);
        rd(2'd2, v); check("pw_count_e4", v, 32'd2);
        tick();
        tick();
        rd(2'd2, v); check("pw_count_e6", v, 32'd0);
        check("pw_irq_e6", {31'd0, irq}, 32'd1);
        rd(2'd1, v); check("pw_preset", v, 32'd100);

        // Reset mid-count at COUNT=2
        do_reset();
        wr(2'd1, 32'd5);
        wr(2'd0, 32'h9);
        wait_count(32'd2, "rmc_reach2");
        reset = 1'b1;
        tick();
        reset = 1'b0;
        rd(2'd2, v); check("rmc_count", v, 32'd0);
        rd(2'd0, v); check("rmc_ctrl", v, 32'd0);
        rd(2'd1, v); check("rmc_preset", v, 32'd0);
        hi = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (irq) hi++;
        end
        check("rmc_no_irq", hi, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/timer_counter.md
Name: timer_counter

Overview:
- Memory-mapped programmable timer/counter on the CPU's external device bus (through the system bridge).
- Its interrupt request line is the hardware interrupt source sampled by the CPU's CP0/exception logic.
- Two modes:
  - Mode 0: one-shot, level interrupt.
  - Mode 1: auto-reload, one-cycle interrupt pulse.
- CPU programs it through word-addressed registers CTRL, PRESET and COUNT.

Parameters:
- RST_PRESET, 32'd0, reset value of the PRESET register.

Ports:
- clk     input   1   system clock; all state updates on the rising edge
- reset   input   1   synchronous, active-high reset
- addr    input   2   word select, CPU address bits [3:2]: 0=CTRL, 1=PRESET, 2=COUNT, 3=reserved
- we      input   1   write enable for the selected register, sampled on the clock edge
- wdata   input   32  write data
- rdata   output  32  combinational read of the selected register
- irq     output  1   interrupt request to the CPU

Behaviour:
- Reset (reset=1 at an edge):
  - CTRL=0, PRESET=RST_PRESET, COUNT=0, pending=0, state=IDLE.
  - irq=0 from that edge onward; reset overrides any simultaneous write.
- CTRL fields:
  - [0] EN (enable); [2:1] MODE; [3] IM (interrupt mask, 1 = allow irq); [31:4] read as 0.
  - MODE values 2 and 3 behave as mode 0 but read back as written.
- Reads and writes:
  - PRESET is read/write.
  - COUNT is read-only; writes to addr 2 or 3 are ignored.
  - addr 3 reads 0.
- Interrupt output: irq = pending & IM (combinational from registers).
- Each CPU write to CTRL or PRESET clears pending.
- FSM states: IDLE, LOAD, CNT, INT. Transitions at each edge, reset excluded:
  - IDLE: EN=1 -> LOAD; else stay. COUNT holds its value.
  - LOAD: COUNT <= PRESET; EN=1 -> CNT; EN=0 -> IDLE.
  - CNT, EN=0 -> IDLE, COUNT frozen.
  - CNT, COUNT > 1 -> COUNT <= COUNT-1, stay.
  - CNT, COUNT <= 1 -> COUNT <= 0, pending <= 1, go to INT.
  - INT, mode 0: EN <= 0, state -> IDLE. pending stays set until a CPU write to CTRL/PRESET or reset.
  - INT, mode 1: pending <= 0, state -> LOAD. irq is high for exactly one cycle per period.
- Latency, with E0 = the edge that writes EN=1 from IDLE and PRESET=N:
  - LOAD at E1, COUNT=N at E2.
  - For N>=1: COUNT=0, INT and irq high after edge E(N+2).
  - N=0 behaves like N=1.
  - Mode-1 period is N+2 cycles.
- Simultaneous events:
  - A CPU write to CTRL in the same cycle that INT clears EN: the CPU write wins, and pending is cleared.
  - A write to PRESET during CNT does not affect the current count; it takes effect at the next LOAD.
  - A write of EN=0 during any state takes the FSM to IDLE at the following edge. COUNT is retained for readback.
- Reset mid-count: everything returns to reset values at that edge. No irq is generated.
- All arithmetic is 32-bit unsigned. COUNT never wraps below 0.

Test Plan:
- Reset with RST_PRESET=0: hold reset 2 cycles -> rdata at addr 0/1/2 all 0, irq=0.
- Mode 0 one-shot:
  - Stimulus: PRESET=5, then CTRL=4'b1001 at E0.
  - COUNT reads 5,4,3,2,1 at E2..E6; after E7 COUNT=0 and irq=1.
  - irq stays 1 for 10+ cycles, CTRL[0] reads 0.
  - Writing CTRL=4'b1000 drops irq at the next edge.
- Mode 1 auto-reload:
  - Stimulus: PRESET=3, CTRL=4'b1011.
  - irq is a one-cycle pulse every 5 cycles, first after E5.
  - Check 4 pulses.
  - Setting IM=0 via a CTRL write suppresses further pulses while COUNT keeps cycling.
- Masked interrupt:
  - Stimulus: PRESET=2, CTRL=4'b0001.
  - irq stays 0, internal pending is set.
  - A later write of IM=1 clears pending (it is a CTRL write), so irq stays 0.
- Disable mid-count:
  - Stimulus: PRESET=10, enable, then write CTRL=0 when COUNT reads 6.
  - COUNT freezes at 5 or 6 per the write-edge timing, with no irq.
  - Re-enabling reloads 10.
- Edge cases:
  - PRESET=0, mode 0 -> irq after E3.
  - A PRESET write during CNT does not change the ongoing count.
  - Reset asserted at COUNT=2 -> COUNT=0, irq never rises.
